serial_adder_nbit: RTL and testbench

//   Parametrised digit-serial adder: adds two WIDTH-bit operands plus carry-in,

---
 rtl/serial_adder_nbit_if.sv | 26 ++
 rtl/serial_adder_nbit.sv | 141 ++++++++++++++
 tb/tb_serial_adder_nbit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_nbit_if.sv
// Handshake and data bundle between a requester and the digit-serial adder.
interface serial_adder_nbit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
    logic             busy;
    logic             done;

    // Requester side: issues operands, observes result and status.
    modport master (
        output start, a, b, carryin,
        input  sum, carryout, overflow, busy, done
    );

    // Adder side: accepts operands, presents registered result and status.
    modport slave (
        input  start, a, b, carryin,
        output sum, carryout, overflow, busy, done
    );
endinterface

// File: rtl/serial_adder_nbit.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, LSB digit first. Result, carry-out and signed overflow are committed
// together when the last digit completes and held until the next commit.
module serial_adder_nbit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_nbit_if.slave bus
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carryout_q, carryout_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]   dig_sum_c;
    logic               dig_cout_c;
    logic               dig_cmsb_c;

    // Ripple adder over the current low digit; also exposes the carry into the
    // digit's top bit, which on the final digit is the carry into the sum MSB.
    always_comb begin
        logic c;
        c          = carry_q;
        dig_sum_c  = '0;
        dig_cmsb_c = carry_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (i == int'(DIGIT) - 1) begin
                dig_cmsb_c = c;
            end
            dig_sum_c[i] = opa_q[i] ^ opb_q[i] ^ c;
            c            = (opa_q[i] & opb_q[i]) | (c & (opa_q[i] ^ opb_q[i]));
        end
        dig_cout_c = c;
    end

    // Next-state and datapath control: IDLE -> RUN (N digits) -> DONE -> IDLE.
    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        res_d      = res_q;
        carry_d    = carry_q;
        count_d    = count_q;
        sum_d      = sum_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.a;
                    opb_d   = bus.b;
                    carry_d = bus.carryin;
                    res_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_d  = 1'b1;
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                carry_d = dig_cout_c;
                res_d   = WIDTH'({dig_sum_c, res_q} >> DIGIT);
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(N - 1)) begin
                    sum_d      = res_d;
                    carryout_d = dig_cout_c;
                    overflow_d = dig_cout_c ^ dig_cmsb_c;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            count_q    <= '0;
            sum_q      <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.sum      = sum_q;
    assign bus.carryout = carryout_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Scoreboard bench for serial_adder_nbit in three configurations:
// W=4/D=1, W=8/D=1 and W=8/D=4.
module tb_serial_adder_nbit;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst4, rst8, rst84;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q4[$];
    exp_t q8[$];
    exp_t q84[$];
    exp_t e4, e8, e84;
    logic [7:0] hold8 = 8'h00;
    logic       prev_done8 = 1'b0;

    serial_adder_nbit_if #(.WIDTH(4)) if4 ();
    serial_adder_nbit_if #(.WIDTH(8)) if8 ();
    serial_adder_nbit_if #(.WIDTH(8)) if84 ();

    serial_adder_nbit #(.WIDTH(4), .DIGIT(1)) u_w4  (.clk(clk), .rst(rst4),  .bus(if4));
    serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u_w8  (.clk(clk), .rst(rst8),  .bus(if8));
    serial_adder_nbit #(.WIDTH(8), .DIGIT(4)) u_w84 (.clk(clk), .rst(rst84), .bus(if84));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop the expected result whenever a done pulse appears.
    always @(negedge clk) begin
        if (if4.done) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_done", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                chk("w4_sum",  32'(if4.sum), 32'(e4.sum[3:0]));
                chk("w4_cout", 32'(if4.carryout), 32'(e4.cout));
                chk("w4_ovf",  32'(if4.overflow), 32'(e4.ovf));
                chk("w4_done_cycle", 32'(cyc), 32'(e4.done_cyc));
            end
        end
    end

    always @(negedge clk) begin
        chk("w8_busy_and_done", 32'(if8.busy & if8.done), 32'd0);
        chk("w8_done_twice",    32'(prev_done8 & if8.done), 32'd0);
        prev_done8 = if8.done;
        if (if8.busy) chk("w8_sum_held", 32'(if8.sum), 32'(hold8));
        if (if8.done) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                chk("w8_sum",  32'(if8.sum), 32'(e8.sum));
                chk("w8_cout", 32'(if8.carryout), 32'(e8.cout));
                chk("w8_ovf",  32'(if8.overflow), 32'(e8.ovf));
                chk("w8_done_cycle", 32'(cyc), 32'(e8.done_cyc));
                hold8 = e8.sum;
            end
        end
    end

    always @(negedge clk) begin
        if (if84.done) begin
            if (q84.size() == 0) begin
                chk("w84_unexpected_done", 32'd1, 32'd0);
            end else begin
                e84 = q84.pop_front();
                chk("w84_sum",  32'(if84.sum), 32'(e84.sum));
                chk("w84_cout", 32'(if84.carryout), 32'(e84.cout));
                chk("w84_ovf",  32'(if84.overflow), 32'(e84.ovf));
                chk("w84_done_cycle", 32'(cyc), 32'(e84.done_cyc));
            end
        end
    end

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                          input logic [3:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        if4.start = 1'b1; if4.a = a; if4.b = b; if4.carryin = cin;
        e.sum = {4'h0, es}; e.cout = ec; e.ovf = eo; e.done_cyc = cyc + 5;
        q4.push_back(e);
        @(negedge clk);
        if4.start = 1'b0; if4.a = ~a; if4.b = ~b; if4.carryin = ~cin;
        repeat (5) @(negedge clk);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.carryin = cin;
        e.sum = es; e.cout = ec; e.ovf = eo; e.done_cyc = cyc + 9;
        q8.push_back(e);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if8.start = 1'b0; if8.a = ~a; if8.b = ~b; if8.carryin = ~cin;
            end
            chk("w8_busy_window", 32'(if8.busy), (k <= 8) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic issue84(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        if84.start = 1'b1; if84.a = a; if84.b = b; if84.carryin = cin;
        e.sum = es; e.cout = ec; e.ovf = eo; e.done_cyc = cyc + 3;
        q84.push_back(e);
        @(negedge clk);
        if84.start = 1'b0; if84.a = ~a; if84.b = ~b; if84.carryin = ~cin;
        repeat (3) @(negedge clk);
    endtask

    // Stall guard.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   e0;
        rst4 = 1'b1; rst8 = 1'b1; rst84 = 1'b1;
        if4.start = 1'b0;  if4.a = '0;  if4.b = '0;  if4.carryin = 1'b0;
        if8.start = 1'b0;  if8.a = '0;  if8.b = '0;  if8.carryin = 1'b0;
        if84.start = 1'b0; if84.a = '0; if84.b = '0; if84.carryin = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_w4_sum",   32'(if4.sum), 32'd0);
        chk("rst_w4_flags", 32'({if4.carryout, if4.overflow, if4.busy, if4.done}), 32'd0);
        chk("rst_w8_sum",   32'(if8.sum), 32'd0);
        chk("rst_w8_flags", 32'({if8.carryout, if8.overflow, if8.busy, if8.done}), 32'd0);
        chk("rst_w84_sum",  32'(if84.sum), 32'd0);
        chk("rst_w84_flags", 32'({if84.carryout, if84.overflow, if84.busy, if84.done}), 32'd0);
        rst4 = 1'b0; rst8 = 1'b0; rst84 = 1'b0;

        issue4(4'b1010, 4'b1101, 1'b1, 4'b1000, 1'b1, 1'b0);
        issue4(4'b1110, 4'b1001, 1'b0, 4'b0111, 1'b1, 1'b1);
        issue4(4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0);

        issue8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        issue8(8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0, 1'b0);

        issue84(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        issue84(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        issue84(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
        issue84(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // start during RUN (cycle 3) and DONE (cycle 9) is ignored; cycle 10 accepted
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h3C; if8.b = 8'h42; if8.carryin = 1'b1;
        e0 = cyc;
        e.sum = 8'h7F; e.cout = 1'b0; e.ovf = 1'b0; e.done_cyc = e0 + 9;
        q8.push_back(e);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3 || k == 9) begin
                if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF; if8.carryin = 1'b1;
            end else if (k == 10) begin
                if8.start = 1'b1; if8.a = 8'h55; if8.b = 8'hAA; if8.carryin = 1'b0;
                e.sum = 8'hFF; e.cout = 1'b0; e.ovf = 1'b0; e.done_cyc = cyc + 9;
                q8.push_back(e);
            end else begin
                if8.start = 1'b0; if8.a = 8'hC3; if8.b = 8'h3C; if8.carryin = 1'b1;
            end
        end
        @(negedge clk);
        if8.start = 1'b0;
        repeat (10) @(negedge clk);

        // reset sampled at edge 4 of an operation aborts it without a done pulse
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'hA5; if8.b = 8'h5A; if8.carryin = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if8.start = 1'b0;
            if (k == 4) rst8 = 1'b1;
        end
        @(negedge clk);
        chk("abort_sum",   32'(if8.sum), 32'd0);
        chk("abort_cout",  32'(if8.carryout), 32'd0);
        chk("abort_ovf",   32'(if8.overflow), 32'd0);
        chk("abort_busy",  32'(if8.busy), 32'd0);
        chk("abort_done",  32'(if8.done), 32'd0);
        hold8 = 8'h00;
        rst8 = 1'b0;
        repeat (12) @(negedge clk);
        issue8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        issue8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        chk("w4_missing_done",  32'(q4.size()), 32'd0);
        chk("w8_missing_done",  32'(q8.size()), 32'd0);
        chk("w84_missing_done", 32'(q84.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
